// File: rtl/ifetch.sv
// ifetch: serialises instruction fetch/decode so the PC advances exactly once per instruction
// Ports:
//   if_clk, if_rst                     clock and synchronous active-high reset
//   if_pc                              current PC from the pc block
//   if_mem_req/addr/ack/rdata          instruction memory read handshake
//   if_rs_addr/rt_addr, if_rs/rt_data  register file read port
//   if_inst, if_inst_valid             instruction register and its DECODE-cycle pulse
//   if_pc_en, if_branch, if_jmp,
//   if_offset_addr                     one-cycle PC advance strobe with branch/jump control
module ifetch #(
    parameter int WAIT_CLK = 4
) (
    input  logic        if_clk,
    input  logic        if_rst,
    input  logic [31:0] if_pc,
    output logic        if_mem_req,
    output logic [31:0] if_mem_addr,
    input  logic        if_mem_ack,
    input  logic [31:0] if_mem_rdata,
    output logic [4:0]  if_rs_addr,
    output logic [4:0]  if_rt_addr,
    input  logic [31:0] if_rs_data,
    input  logic [31:0] if_rt_data,
    output logic [31:0] if_inst,
    output logic        if_inst_valid,
    output logic        if_pc_en,
    output logic        if_branch,
    output logic        if_jmp,
    output logic [31:0] if_offset_addr
);
    typedef enum logic [1:0] {WAIT, FETCH, DECODE, ISSUE} state_t;
    state_t      state, state_n;
    logic [31:0] cnt;
    logic [31:0] ir;
    logic [5:0]  opcode;
    logic        is_br, is_j, br_d;
    logic [31:0] off_d;
    always_ff @(posedge if_clk) begin
        if (if_rst) state <= WAIT;
        else        state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            WAIT:    state_n = (cnt == 32'(WAIT_CLK)) ? FETCH : WAIT;
            FETCH:   state_n = if_mem_ack ? DECODE : FETCH;
            DECODE:  state_n = ISSUE;
            default: state_n = FETCH;
        endcase
    end
    // beq/bne share opcode[5:1]; opcode[0] selects the inverted compare for bne.
    // j/jal share opcode[5:1] as well; jal links nothing here.
    always_comb begin
        opcode = ir[31:26];
        is_br  = opcode[5:1] == 5'b00010;
        is_j   = opcode[5:1] == 5'b00001;
        br_d   = is_br & ((if_rs_data == if_rt_data) ^ opcode[0]);
        off_d  = is_br ? {{16{ir[15]}}, ir[15:0]} : is_j ? {6'b0, ir[25:0]} : 32'b0;
    end
    always_ff @(posedge if_clk) begin
        if (if_rst) begin
            cnt            <= '0;
            ir             <= '0;
            if_mem_addr    <= '0;
            if_branch      <= 1'b0;
            if_jmp         <= 1'b0;
            if_offset_addr <= '0;
        end else begin
            if (state == WAIT) cnt <= cnt + 1;
            // if_pc already reflects the advanced PC during ISSUE, so sampling here picks up the new address.
            if (state_n == FETCH && state != FETCH) if_mem_addr <= if_pc;
            if (state == FETCH && if_mem_ack) ir <= if_mem_rdata;
            if (state == DECODE) begin
                if_branch      <= br_d;
                if_jmp         <= is_j;
                if_offset_addr <= off_d;
            end else if (state == ISSUE) begin
                if_branch      <= 1'b0;
                if_jmp         <= 1'b0;
                if_offset_addr <= '0;
            end
        end
    end
    assign if_mem_req    = state == FETCH;
    assign if_inst_valid = state == DECODE;
    assign if_pc_en      = state == ISSUE;
    assign if_inst       = ir;
    assign if_rs_addr    = ir[25:21];
    assign if_rt_addr    = ir[20:16];
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed self-checking bench for ifetch
module tb_ifetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_q;
    logic [31:0] if_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data = '0, rt_data = '0;
    logic [31:0] inst;
    logic        inst_valid, pc_en, branch, jmp;
    logic [31:0] offset;
    int n_tests = 0;
    int n_fail  = 0;

    ifetch #(.WAIT_CLK(4)) dut (
        .if_clk(clk), .if_rst(rst), .if_pc(if_pc),
        .if_mem_req(mem_req), .if_mem_addr(mem_addr), .if_mem_ack(mem_ack), .if_mem_rdata(mem_rdata),
        .if_rs_addr(rs_addr), .if_rt_addr(rt_addr), .if_rs_data(rs_data), .if_rt_data(rt_data),
        .if_inst(inst), .if_inst_valid(inst_valid), .if_pc_en(pc_en),
        .if_branch(branch), .if_jmp(jmp), .if_offset_addr(offset)
    );

    always #5 clk = ~clk;

    // Zero-delay pc stand-in: the advanced PC is visible while pc_en is high.
    always @(posedge clk) begin
        if (rst) pc_q <= '0;
        else if (pc_en) pc_q <= pc_q + 32'd4;
    end
    assign if_pc = pc_q + (pc_en ? 32'd4 : 32'd0);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one memory read from FETCH; returns sampled in DECODE.
    task automatic fetch(input logic [31:0] word, input int delay);
        mem_rdata = word;
        mem_ack   = 1'b0;
        for (int i = 0; i < delay; i++) tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({mem_req, inst_valid, pc_en, branch, jmp} !== 5'b0 || mem_addr !== 32'b0 || inst !== 32'b0 ||
            offset !== 32'b0 || rs_addr !== 5'b0 || rt_addr !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b val=%b pc_en=%b br=%b j=%b addr=%h inst=%h off=%h rs=%0d rt=%0d, required all 0",
                     mem_req, inst_valid, pc_en, branch, jmp, mem_addr, inst, offset, rs_addr, rt_addr);
        end
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_tests++;
            if (mem_req !== 1'b0 || pc_en !== 1'b0) begin
                n_fail++;
                $display("FAIL startup_idle edge %0d: req=%b pc_en=%b, required 0 0", i, mem_req, pc_en);
            end
        end
        tick();
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL startup_req: req=%b addr=%h, required 1 00000000", mem_req, mem_addr);
        end
    endtask

    task automatic test_sequential;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (mem_req !== 1'b1 || mem_addr !== 32'(4 * k)) begin
                n_fail++;
                $display("FAIL seq_fetch %0d: req=%b addr=%h, required 1 %h", k, mem_req, mem_addr, 32'(4 * k));
            end
            tick();
            n_tests++;
            if (inst_valid !== 1'b1 || mem_req !== 1'b0 || pc_en !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_decode %0d: val=%b req=%b pc_en=%b, required 1 0 0", k, inst_valid, mem_req, pc_en);
            end
            tick();
            n_tests++;
            if (pc_en !== 1'b1 || branch !== 1'b0 || jmp !== 1'b0 || inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_issue %0d: pc_en=%b br=%b j=%b val=%b, required 1 0 0 0", k, pc_en, branch, jmp, inst_valid);
            end
            tick();
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_beq_taken;
        fetch(32'h1085FFFD, 0);
        n_tests++;
        if (inst_valid !== 1'b1 || inst !== 32'h1085FFFD || rs_addr !== 5'd4 || rt_addr !== 5'd5) begin
            n_fail++;
            $display("FAIL beq_decode: val=%b inst=%h rs=%0d rt=%0d, required 1 1085fffd 4 5", inst_valid, inst, rs_addr, rt_addr);
        end
        rs_data = 32'd7;
        rt_data = 32'd7;
        tick();
        n_tests++;
        if (pc_en !== 1'b1 || branch !== 1'b1 || jmp !== 1'b0 || offset !== 32'hFFFFFFFD) begin
            n_fail++;
            $display("FAIL beq_issue: pc_en=%b br=%b j=%b off=%h, required 1 1 0 fffffffd", pc_en, branch, jmp, offset);
        end
        tick();
        n_tests++;
        if (pc_en !== 1'b0 || branch !== 1'b0 || offset !== 32'h0 || mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL beq_clear: pc_en=%b br=%b off=%h req=%b, required 0 0 00000000 1", pc_en, branch, offset, mem_req);
        end
    endtask

    task automatic test_bne_not_taken;
        fetch(32'h1485FFFD, 0);
        rs_data = 32'd7;
        rt_data = 32'd7;
        tick();
        n_tests++;
        if (pc_en !== 1'b1 || branch !== 1'b0 || jmp !== 1'b0 || offset !== 32'hFFFFFFFD) begin
            n_fail++;
            $display("FAIL bne_issue: pc_en=%b br=%b j=%b off=%h, required 1 0 0 fffffffd", pc_en, branch, jmp, offset);
        end
        tick();
        fetch(32'h1485FFFD, 0);
        rt_data = 32'd8;
        tick();
        n_tests++;
        if (pc_en !== 1'b1 || branch !== 1'b1 || jmp !== 1'b0) begin
            n_fail++;
            $display("FAIL bne_taken_issue: pc_en=%b br=%b j=%b, required 1 1 0", pc_en, branch, jmp);
        end
        tick();
        rt_data = 32'd7;
    endtask

    task automatic test_jump;
        fetch(32'h08000040, 0);
        tick();
        n_tests++;
        if (pc_en !== 1'b1 || jmp !== 1'b1 || branch !== 1'b0 || offset !== 32'h00000040) begin
            n_fail++;
            $display("FAIL j_issue: pc_en=%b j=%b br=%b off=%h, required 1 1 0 00000040", pc_en, jmp, branch, offset);
        end
        tick();
        fetch(32'h0FFFFFFF, 0);
        tick();
        n_tests++;
        if (pc_en !== 1'b1 || jmp !== 1'b1 || branch !== 1'b0 || offset !== 32'h03FFFFFF) begin
            n_fail++;
            $display("FAIL jal_issue: pc_en=%b j=%b br=%b off=%h, required 1 1 0 03ffffff", pc_en, jmp, branch, offset);
        end
        tick();
    endtask

    task automatic test_slow_memory;
        logic [31:0] a0;
        a0 = mem_addr;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (mem_req !== 1'b1 || mem_addr !== a0 || inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL slow_hold %0d: req=%b addr=%h val=%b, required 1 %h 0", i, mem_req, mem_addr, inst_valid, a0);
            end
            tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_tests++;
        if (inst_valid !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL slow_decode: val=%b req=%b, required 1 0", inst_valid, mem_req);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_fetch;
        int pc_en_seen;
        mem_ack = 1'b0;
        tick();
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        n_tests++;
        if (mem_req !== 1'b0 || inst !== 32'h0 || mem_addr !== 32'h0 || pc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: req=%b inst=%h addr=%h pc_en=%b, required 0 00000000 00000000 0", mem_req, inst, mem_addr, pc_en);
        end
        rst = 1'b0;
        pc_en_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pc_en === 1'b1 || inst_valid === 1'b1 || mem_req === 1'b1) pc_en_seen++;
        end
        n_tests++;
        if (pc_en_seen != 0 || inst !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_late_ack: active cycles=%0d inst=%h, required 0 00000000", pc_en_seen, inst);
        end
        mem_ack = 1'b0;
        tick();
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_restart: req=%b addr=%h, required 1 00000000", mem_req, mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_beq_taken();
        test_bne_not_taken();
        test_jump();
        test_slow_memory();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
